pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer and fetch controller for the 9-bit-instruction core. Drives the 16-bit `pc_in` address of the instruction ROM and advances it each cycle by increment, relative branch, or absolute jump. Runs a start/run/halt control state machine and counts retired instructions. Sits between the top-level testbench/host control and the ROM plus decode/execute stage. The ROM is combinational, so fetch, decode and the branch decision complete in the same cycle.

## Interface
Parameters:
- `PC_W`, 16, program-counter width; ROM address width.
- `START_ADDR`, 16'h0000, PC loaded on reset and on every `start`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins or restarts execution at `START_ADDR`.
- `stall`  in  1  execute stage not ready; hold the PC and retire nothing.
- `halt_req`  in  1  decoded halt instruction in the current cycle.
- `br_taken`  in  1  the current instruction redirects the PC.
- `br_rel`  in  1  1 = relative branch using `br_offset`; 0 = absolute jump using `br_target`.
- `br_offset`  in  8  signed two's-complement offset (the ROM `immediate` field).
- `br_target`  in  PC_W  absolute jump target.
- `pc_out`  out  PC_W  current PC; connects to the ROM `pc_in`.
- `instr_valid`  out  1  the ROM output at `pc_out` is a live instruction this cycle.
- `running`  out  1  state is RUN.
- `done`  out  1  state is HALT.
- `retired_cnt`  out  16  instructions retired since the last start; saturating.

## Operation
- States: IDLE, RUN, HALT.
- IDLE: PC holds `START_ADDR`. `start` moves to RUN; PC stays `START_ADDR` and `retired_cnt` clears to 0.
- RUN with `stall`=1: PC, count and state all hold. `halt_req` and `br_*` are ignored; the requester keeps them asserted until stall drops.
- RUN with `stall`=0 retires the current instruction: `retired_cnt` increments and saturates at 16'hFFFF. Next-state priority:
  - `halt_req`: go to HALT. PC holds the address of the halt instruction.
  - else `br_taken`, `br_rel`=1: PC ← PC + sext16(`br_offset`), mod 2^16.
  - else `br_taken`, `br_rel`=0: PC ← `br_target`.
  - else: PC ← PC + 1, mod 2^16 (16'hFFFF wraps to 16'h0000).
- The halt instruction counts as retired.
- `start` while in RUN is ignored.
- HALT: PC and count hold. `start` restarts, behaving as in IDLE (PC ← `START_ADDR`, count ← 0, go to RUN).
- `instr_valid` = `running` & ~`stall`.
- `reset_n` low overrides every other input, including mid-run.

## Timing
- Reset values at the edge after `reset_n`=0: state IDLE, `pc_out`=`START_ADDR`, `instr_valid`=0, `running`=0, `done`=0, `retired_cnt`=0.
- `start` sampled high at edge N: `running`=1 from cycle N+1, and `pc_out`=`START_ADDR` in that cycle.
- PC redirect latency is 1 cycle: a branch sampled at edge N shows the target on `pc_out` from cycle N+1. No delay slots and no bubbles.
- `done` rises in the cycle after `halt_req` is sampled; `running` falls in the same cycle.
- Every output is a registered state decode, except `instr_valid`, which also depends combinationally on `stall`.
- Simultaneous `halt_req` and `br_taken`: halt wins.
- Simultaneous `stall` and anything else: stall wins.

## Structure
- Shared package `core_pkg` holds:
  - the `pc_state_t` enum (IDLE, RUN, HALT);
  - `PC_W`;
  - `INSTR_W`=9;
  - the field positions used by the decoder: format[8], opcode[7:4], sign[3], operand[2:0], immediate[7:0].
- One sub-module, `pc_next_calc`: a purely combinational next-PC mux and adder (increment, relative, absolute, hold).
- The state register, counter and output decode live in `pc_sequencer`.

## Test plan
- Reset then `start`: `pc_out` sequence is 0,1,2,3 on consecutive cycles. `retired_cnt`=3 after 3 unstalled cycles. `instr_valid`=1.
- Relative branch at PC=16'h0013 with offset 8'hFE: next PC=16'h0011. Offset 8'h05 from 16'hFFFE: next PC=16'h0003 (wrap).
- Absolute jump to 16'h0040 asserted together with `stall`=1 for 2 cycles: PC holds 2 cycles, then reads 16'h0040. Count advances by 1 only.
- `halt_req` with `br_taken` at PC=16'h0079: `done`=1 next cycle, PC stays 16'h0079, count includes the halt. A further `start` gives PC=0, count=0, RUN.
- `reset_n`=0 mid-run at PC=16'h0025 with `retired_cnt`=37: next cycle IDLE, PC=0, count=0, all flags 0. `start` held high during reset is ignored.
- Counter saturation: preload by running 65 540 unstalled cycles; `retired_cnt` stays 16'hFFFF.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit-instruction core: sequencer states,
// next-PC select codes, datapath widths and decoder field positions.
package core_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  // Instruction field positions used by the decoder
  localparam int FMT_BIT    = 8;
  localparam int OPC_HI     = 7;
  localparam int OPC_LO     = 4;
  localparam int SIGN_BIT   = 3;
  localparam int OPERAND_HI = 2;
  localparam int OPERAND_LO = 0;
  localparam int IMM_HI     = 7;
  localparam int IMM_LO     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_REL  = 2'd2,
    SEL_ABS  = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold, increment, relative branch with a
// sign-extended 8-bit offset, or absolute jump. All arithmetic wraps mod 2^PC_W.
module pc_next_calc
  import core_pkg::*;
#(
  parameter int PC_W = core_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  pc_sel_t         sel,
  input  logic [7:0]      br_offset,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] offset_ext;

  // Sign-extend the branch offset to the PC width
  always_comb begin
    offset_ext = {{(PC_W-8){br_offset[7]}}, br_offset};
  end

  // Pick the next PC; the adders drop the carry so the PC wraps naturally
  always_comb begin
    pc_next = pc;
    unique case (sel)
      SEL_HOLD: pc_next = pc;
      SEL_INC:  pc_next = pc + {{(PC_W-1){1'b0}}, 1'b1};
      SEL_REL:  pc_next = pc + offset_ext;
      SEL_ABS:  pc_next = br_target;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer and fetch controller. Runs the IDLE/RUN/HALT
// control machine, steps the PC each unstalled RUN cycle and counts retired
// instructions with a saturating counter.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int              PC_W       = core_pkg::PC_W,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             br_taken,
  input  logic             br_rel,
  input  logic [7:0]       br_offset,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc_out,
  output logic             instr_valid,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired_cnt
);

  pc_state_t        state, state_next;
  pc_sel_t          pc_sel;
  logic             load_start;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [PC_W-1:0]  pc, pc_calc, pc_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  pc_next_calc #(
    .PC_W(PC_W)
  ) u_next_calc (
    .pc        (pc),
    .sel       (pc_sel),
    .br_offset (br_offset),
    .br_target (br_target),
    .pc_next   (pc_calc)
  );

  // State, PC and retire counter registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= START_ADDR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and datapath control; stall freezes everything while running
  always_comb begin
    state_next = state;
    pc_sel     = SEL_HOLD;
    load_start = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          state_next = RUN;
          load_start = 1'b1;
          cnt_clear  = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_inc = 1'b1;
          if (halt_req) begin
            state_next = HALT;
          end else if (br_taken) begin
            pc_sel = br_rel ? SEL_REL : SEL_ABS;
          end else begin
            pc_sel = SEL_INC;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next PC and retire count; the count sticks at all-ones
  always_comb begin
    pc_next  = load_start ? START_ADDR : pc_calc;
    cnt_next = cnt;
    if (cnt_clear) begin
      cnt_next = '0;
    end else if (cnt_inc && (cnt != {CNT_W{1'b1}})) begin
      cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output decode; only instr_valid looks at a live input
  always_comb begin
    pc_out      = pc;
    retired_cnt = cnt;
    running     = (state == RUN);
    done        = (state == HALT);
    instr_valid = (state == RUN) && !stall;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps followed by a
// randomized run, compared against a behavioural model of the sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_rel = 1'b0;
  logic [7:0]  br_offset = '0;
  logic [15:0] br_target = '0;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        running;
  logic        done;
  logic [15:0] retired_cnt;

  int tests = 0;
  int failures = 0;

  // Behavioural model: running/halted flags, PC and count as plain integers
  bit m_running = 1'b0;
  bit m_done    = 1'b0;
  int m_pc      = 0;
  int m_cnt     = 0;

  localparam int START = 0;

  pc_sequencer #(
    .PC_W(16),
    .START_ADDR(16'h0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stall       (stall),
    .halt_req    (halt_req),
    .br_taken    (br_taken),
    .br_rel      (br_rel),
    .br_offset   (br_offset),
    .br_target   (br_target),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .running     (running),
    .done        (done),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, and advance the model by the same rules
  task automatic applyStimulus(input logic rst_i, input logic start_i,
                               input logic stall_i, input logic halt_i,
                               input logic taken_i, input logic rel_i,
                               input logic [7:0] off_i, input logic [15:0] tgt_i);
    bit n_running, n_done;
    int n_pc, n_cnt;
    reset_n   = rst_i;
    start     = start_i;
    stall     = stall_i;
    halt_req  = halt_i;
    br_taken  = taken_i;
    br_rel    = rel_i;
    br_offset = off_i;
    br_target = tgt_i;
    n_running = m_running;
    n_done    = m_done;
    n_pc      = m_pc;
    n_cnt     = m_cnt;
    if (!rst_i) begin
      n_running = 0; n_done = 0; n_pc = START; n_cnt = 0;
    end else if (!m_running) begin
      if (start_i) begin
        n_running = 1; n_done = 0; n_pc = START; n_cnt = 0;
      end
    end else if (!stall_i) begin
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (halt_i) begin
        n_running = 0; n_done = 1;
      end else if (taken_i) begin
        n_pc = rel_i ? ((m_pc + int'($signed(off_i))) & 16'hFFFF) : int'(tgt_i);
      end else begin
        n_pc = (m_pc + 1) & 16'hFFFF;
      end
    end
    @(posedge clk);
    #1;
    m_running = n_running;
    m_done    = n_done;
    m_pc      = n_pc;
    m_cnt     = n_cnt;
  endtask

  // Idle cycle with everything deasserted except reset
  task automatic stepIdle();
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against the model
  task automatic checkOutput(input string tag);
    checkValue({tag, ".pc_out"},      32'(pc_out),      32'(m_pc));
    checkValue({tag, ".running"},     32'(running),     32'(m_running));
    checkValue({tag, ".done"},        32'(done),        32'(m_done));
    checkValue({tag, ".retired_cnt"}, 32'(retired_cnt), 32'(m_cnt));
    checkValue({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_running & ~stall));
  endtask

  initial begin
    // Reset with start held high: start must be ignored
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    checkOutput("reset");
    checkValue("reset.pc_const", 32'(pc_out), 32'h0);

    // Start, then three unstalled cycles: PC 0,1,2,3
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    checkOutput("start");
    checkValue("start.running", 32'(running), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      stepIdle();
      checkOutput("seq");
      checkValue("seq.pc_const", 32'(pc_out), 32'(i));
    end
    checkValue("seq.cnt_const", 32'(retired_cnt), 32'd3);
    checkValue("seq.valid_const", 32'(instr_valid), 32'h1);

    // Relative branch backwards and relative wrap past 16'hFFFF
    applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 16'h0013);
    checkOutput("jmp13");
    applyStimulus(1, 0, 0, 0, 1, 1, 8'hFE, 16'h0000);
    checkOutput("rel_back");
    checkValue("rel_back.pc_const", 32'(pc_out), 32'h0011);
    applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 16'hFFFE);
    applyStimulus(1, 0, 0, 0, 1, 1, 8'h05, 16'h0000);
    checkOutput("rel_wrap");
    checkValue("rel_wrap.pc_const", 32'(pc_out), 32'h0003);

    // Increment wrap from 16'hFFFF to 0
    applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 16'hFFFF);
    stepIdle();
    checkValue("inc_wrap.pc_const", 32'(pc_out), 32'h0000);

    // Absolute jump held under stall for two cycles
    begin
      logic [15:0] pc_before, cnt_before;
      pc_before  = pc_out;
      cnt_before = retired_cnt;
      applyStimulus(1, 0, 1, 0, 1, 0, 8'h00, 16'h0040);
      checkOutput("stall1");
      applyStimulus(1, 0, 1, 0, 1, 0, 8'h00, 16'h0040);
      checkOutput("stall2");
      checkValue("stall.pc_hold", 32'(pc_out), 32'(pc_before));
      applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 16'h0040);
      checkOutput("stall_rel");
      checkValue("stall_rel.pc_const", 32'(pc_out), 32'h0040);
      checkValue("stall_rel.cnt_step", 32'(retired_cnt), 32'(cnt_before + 16'd1));
    end

    // Halt wins over a simultaneous branch
    applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 16'h0079);
    begin
      logic [15:0] cnt_before;
      cnt_before = retired_cnt;
      applyStimulus(1, 0, 0, 1, 1, 0, 8'h00, 16'h0100);
      checkOutput("halt");
      checkValue("halt.done", 32'(done), 32'h1);
      checkValue("halt.pc_const", 32'(pc_out), 32'h0079);
      checkValue("halt.cnt_step", 32'(retired_cnt), 32'(cnt_before + 16'd1));
    end
    stepIdle();
    checkOutput("halt_hold");
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    checkOutput("restart");
    checkValue("restart.cnt_const", 32'(retired_cnt), 32'h0);

    // Run to PC 0x25 with count 37, then reset mid-run with start held
    for (int i = 0; i < 37; i++) stepIdle();
    checkValue("pre_rst.pc_const", 32'(pc_out), 32'h0025);
    checkValue("pre_rst.cnt_const", 32'(retired_cnt), 32'd37);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    checkOutput("mid_reset");
    checkValue("mid_reset.running", 32'(running), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    checkOutput("post_reset_idle");

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                    1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
      checkOutput("rand");
    end

    // Counter saturation after more than 2^16 retirements
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    for (int i = 0; i < 65540; i++) stepIdle();
    checkOutput("sat");
    checkValue("sat.cnt_const", 32'(retired_cnt), 32'h0000FFFF);
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 16'h0000);
    checkValue("sat.stall_valid", 32'(instr_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
